mc_ctrl_fsm: RTL and testbench

//  Multi-cycle main controller. It is the driving end of the ALU interface: it sources alu_op (0000 add, 0001 sub)
//  and operand selects, and it consumes the ALU zero flag for beq. It sequences add, addi, lw, sw and beq over 3-5

---
 rtl/mc_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
// Module      : mc_ctrl_fsm
// Description : Multi-cycle main controller for add/addi/lw/sw/beq with a
//               memory-handshake stall and bus-error timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       bus_err,
    output logic       retired
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_R_EXE    = 4'd3;
    localparam logic [3:0] S_R_WB     = 4'd4;
    localparam logic [3:0] S_I_EXE    = 4'd5;
    localparam logic [3:0] S_I_WB     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       is_sw_q, is_sw_d;
    logic       w_timeout;

    assign w_timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = 8'd0;
        is_sw_d    = is_sw_q;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        retired    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    state_d   = S_DECODE;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DECODE: begin
                // ALU computes the branch target here so BRANCH can use ALUOut
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD) begin
                            state_d = S_R_EXE;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    OP_ADDI: state_d = S_I_EXE;
                    OP_LW: begin
                        is_sw_d = 1'b0;
                        state_d = S_MEM_ADDR;
                    end
                    OP_SW: begin
                        is_sw_d = 1'b1;
                        state_d = S_MEM_ADDR;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_R_EXE: begin
                alu_src_a = 1'b1;
                state_d   = S_R_WB;
            end

            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retired   = 1'b1;
                state_d   = S_FETCH;
            end

            S_I_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_I_WB;
            end

            S_I_WB: begin
                reg_write = 1'b1;
                retired   = 1'b1;
                state_d   = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = is_sw_q ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retired    = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retired = 1'b1;
                    state_d = S_FETCH;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_BRANCH: begin
                alu_op    = ALU_SUB;
                alu_src_a = 1'b1;
                pc_src    = 1'b1;
                pc_write  = zero;
                retired   = 1'b1;
                state_d   = S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_sw_q <= is_sw_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ============================================================================
// Module      : tb_mc_ctrl_fsm
// Description : Directed scoreboard bench for mc_ctrl_fsm output sequencing.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord, mem_read, mem_write, ir_write, pc_write, pc_src;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op, bus_err, retired;

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] exp_q[$];
    logic [18:0] w_obs;

    mc_ctrl_fsm #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
        .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    assign w_obs = {alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                    ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
                    illegal_op, bus_err, retired};

    function automatic logic [18:0] ov(
        input logic [3:0] op, input logic a, input logic [1:0] b,
        input logic io, mr, mw, irw, pcw, pcs, rw, rd, m2r, ill, be, ret);
        return {op, a, b, io, mr, mw, irw, pcw, pcs, rw, rd, m2r, ill, be, ret};
    endfunction

    //                                     op  a  b  io mr mw irw pcw pcs rw rd m2r ill be ret
    localparam logic [18:0] E_ZERO   = 19'd0;
    localparam logic [18:0] E_FWAIT  = ov(4'd0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_FRDY   = ov(4'd0, 0, 2'd1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_DEC    = ov(4'd0, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_DECILL = ov(4'd0, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [18:0] E_REXE   = ov(4'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_RWB    = ov(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    localparam logic [18:0] E_IEXE   = ov(4'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_IWB    = ov(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    localparam logic [18:0] E_MADDR  = ov(4'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_MRD    = ov(4'd0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_MWB    = ov(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    localparam logic [18:0] E_MWR    = ov(4'd0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [18:0] E_MWRDN  = ov(4'd0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    localparam logic [18:0] E_MWRTO  = ov(4'd0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    localparam logic [18:0] E_BRT    = ov(4'd1, 1, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    localparam logic [18:0] E_BRN    = ov(4'd1, 1, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

    task automatic check(input string tag);
        logic [18:0] e;
        e = exp_q.pop_front();
        n_checks++;
        assert (w_obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%05h expected=%05h", tag, w_obs, e);
        end
    endtask

    task automatic check_now(input logic [18:0] e, input string tag);
        exp_q.push_back(e);
        check(tag);
    endtask

    // One clock cycle: drive inputs just after the edge, compare at the falling edge
    task automatic step(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy,
                        input logic [18:0] e, input string tag);
        @(posedge clk);
        #1;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back(e);
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        #3;
        check_now(E_ZERO, "reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_now(E_ZERO, "idle_after_reset");

        // add
        step(6'h00, 6'h20, 0, 1, E_FRDY, "add_fetch");
        step(6'h00, 6'h20, 0, 1, E_DEC,  "add_decode");
        step(6'h00, 6'h20, 0, 1, E_REXE, "add_exe");
        step(6'h00, 6'h20, 0, 1, E_RWB,  "add_wb");

        // lw with 3 wait cycles; opcode flips to sw after DECODE and must be ignored
        step(6'h23, 6'h00, 0, 1, E_FRDY,  "lw_fetch");
        step(6'h23, 6'h00, 0, 1, E_DEC,   "lw_decode");
        step(6'h2B, 6'h00, 0, 1, E_MADDR, "lw_addr");
        for (int i = 0; i < 3; i++)
            step(6'h2B, 6'h00, 0, 0, E_MRD, "lw_rd_wait");
        step(6'h2B, 6'h00, 0, 1, E_MRD, "lw_rd_done");
        step(6'h2B, 6'h00, 0, 1, E_MWB, "lw_wb");

        // beq taken, then not taken
        step(6'h04, 6'h00, 0, 1, E_FRDY, "beq1_fetch");
        step(6'h04, 6'h00, 0, 1, E_DEC,  "beq1_decode");
        step(6'h04, 6'h00, 1, 1, E_BRT,  "beq_taken");
        step(6'h04, 6'h00, 0, 1, E_FRDY, "beq2_fetch");
        step(6'h04, 6'h00, 0, 1, E_DEC,  "beq2_decode");
        step(6'h04, 6'h00, 0, 1, E_BRN,  "beq_not_taken");

        // addi with a fetch stall
        step(6'h08, 6'h00, 0, 0, E_FWAIT, "addi_fetch_wait");
        step(6'h08, 6'h00, 0, 1, E_FRDY,  "addi_fetch");
        step(6'h08, 6'h00, 0, 1, E_DEC,   "addi_decode");
        step(6'h08, 6'h00, 0, 1, E_IEXE,  "addi_exe");
        step(6'h08, 6'h00, 0, 1, E_IWB,   "addi_wb");

        // sw zero-wait
        step(6'h2B, 6'h00, 0, 1, E_FRDY,  "sw_fetch");
        step(6'h2B, 6'h00, 0, 1, E_DEC,   "sw_decode");
        step(6'h2B, 6'h00, 0, 1, E_MADDR, "sw_addr");
        step(6'h2B, 6'h00, 0, 1, E_MWRDN, "sw_write");

        // sw timeout: 14 waits, bus error on the 15th, then refetch
        step(6'h2B, 6'h00, 0, 1, E_FRDY,  "swto_fetch");
        step(6'h2B, 6'h00, 0, 1, E_DEC,   "swto_decode");
        step(6'h2B, 6'h00, 0, 1, E_MADDR, "swto_addr");
        for (int i = 0; i < 14; i++)
            step(6'h2B, 6'h00, 0, 0, E_MWR, "swto_wait");
        step(6'h2B, 6'h00, 0, 0, E_MWRTO, "swto_bus_err");
        step(6'h3F, 6'h00, 0, 1, E_FRDY,  "after_timeout_fetch");

        // op 0x3F illegal, then R-type with sub funct illegal
        step(6'h3F, 6'h00, 0, 1, E_DECILL, "illegal_op3f");
        step(6'h00, 6'h22, 0, 1, E_FRDY,   "ill2_fetch");
        step(6'h00, 6'h22, 0, 1, E_DECILL, "illegal_funct22");

        // sw ready arrives exactly in the timeout cycle: success, no bus error
        step(6'h2B, 6'h00, 0, 1, E_FRDY,  "swlate_fetch");
        step(6'h2B, 6'h00, 0, 1, E_DEC,   "swlate_decode");
        step(6'h2B, 6'h00, 0, 1, E_MADDR, "swlate_addr");
        for (int i = 0; i < 14; i++)
            step(6'h2B, 6'h00, 0, 0, E_MWR, "swlate_wait");
        step(6'h2B, 6'h00, 0, 1, E_MWRDN, "swlate_done");

        // async reset in the middle of a store
        step(6'h2B, 6'h00, 0, 1, E_FRDY,  "swrst_fetch");
        step(6'h2B, 6'h00, 0, 1, E_DEC,   "swrst_decode");
        step(6'h2B, 6'h00, 0, 1, E_MADDR, "swrst_addr");
        step(6'h2B, 6'h00, 0, 0, E_MWR,   "swrst_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check_now(E_ZERO, "reset_mid_store");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_now(E_ZERO, "idle_after_mid_reset");
        step(6'h00, 6'h20, 0, 1, E_FRDY, "fetch_after_mid_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
